fifo_write_master: RTL
======================

FIFO_WRITE_MASTER -- requirements
Module: fifo_write_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one data word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the statistics counters.
REQ-003 SHALL have port w_clk  input  1  write-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_data  input  DATA_WIDTH  upstream word.
REQ-007 SHALL have port s_last  input  1  word is the last of a packet.
REQ-008 SHALL have port s_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port flush  input  1  discard all buffered, unpushed words.
REQ-010 SHALL have port fifo_full  input  1  async FIFO full flag, write domain.
REQ-011 SHALL have port fifo_w_en  output  1  FIFO write strobe.
REQ-012 SHALL have port fifo_w_data  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port busy  output  1  buffer non-empty or flush in progress.
REQ-014 SHALL have ports word_count, pkt_count and drop_count  output  CNT_WIDTH each: words pushed, packets pushed and words discarded.

Function
REQ-015 SHALL hold words in a 2-entry in-order skid buffer; each entry stores {s_last, s_data}; occupancy cnt is 0..2.
REQ-016 SHALL run a state machine with states IDLE (cnt=0), RUN (cnt>0 and fifo_full=0), STALL (cnt>0 and fifo_full=1) and FLUSH; outside FLUSH the next state is recomputed every cycle from the next cnt and the current fifo_full.
REQ-017 SHALL drive s_ready = (cnt!=2) and state!=FLUSH and flush=0, combinationally.
REQ-018 SHALL accept a word when s_valid and s_ready are both 1 at a rising edge.
REQ-019 SHALL drive fifo_w_en = (cnt!=0) and fifo_full=0 and state!=FLUSH and flush=0, combinationally; fifo_w_data SHALL equal the head entry data.
REQ-020 SHALL pop the head entry at each edge where fifo_w_en=1.
REQ-021 SHALL give a word accepted at edge N its first presentation on fifo_w_en/fifo_w_data in cycle N+1, i.e. one-cycle minimum latency.
REQ-022 SHALL leave cnt unchanged and preserve order on a simultaneous accept and pop.
REQ-023 SHALL never assert fifo_w_en while fifo_full=1; a head word stalled by fifo_full SHALL stay stable on fifo_w_data.
REQ-024 SHALL increment word_count by 1 per pop, and pkt_count by 1 per pop whose stored last bit is 1; both SHALL wrap modulo 2^CNT_WIDTH.
REQ-025 SHALL, at an edge where flush=1, clear cnt, add the pre-flush cnt to drop_count (wrapping), and enter FLUSH.
REQ-026 SHALL, while flush=1, neither accept nor pop.
REQ-027 SHALL remain in FLUSH exactly one cycle with s_ready=0 and fifo_w_en=0, then go to IDLE; a flush=1 during FLUSH SHALL re-enter FLUSH with nothing more dropped.
REQ-028 SHALL drive busy = (cnt!=0) or state==FLUSH.

Reset
REQ-029 SHALL, at a rising edge with resetn=0, set cnt=0, state=IDLE and word_count=pkt_count=drop_count=0; as a result s_ready=1 from the next cycle, and fifo_w_en=0 and busy=0.
REQ-030 SHALL discard buffered words without counting them as dropped when reset is asserted mid-operation; resetn SHALL take priority over flush.

Verification
REQ-031 SHALL cover streaming with fifo_full=0: 4 words A0..A3 on back-to-back s_valid, A3 with s_last -> fifo_w_en high for 4 consecutive cycles starting one cycle after A0, data in order, word_count=4, pkt_count=1.
REQ-032 SHALL cover backpressure: fifo_full=1 held and 3 words offered -> 2 accepted, s_ready=0 on the third, fifo_w_en=0, state STALL; release fifo_full -> 2 pushes in order, then the third word is accepted.
REQ-033 SHALL cover full toggling: fifo_full rises in the same cycle a head word is presented -> no write that cycle, the same word is written on the first cycle fifo_full=0.
REQ-034 SHALL cover flush: flush with cnt=2 -> drop_count=2, state FLUSH for one cycle, s_ready=0 that cycle, and the next accepted word is the first one pushed.
REQ-035 SHALL cover reset mid-stream: resetn=0 with cnt=1 and all counters non-zero -> all counters 0, fifo_w_en=0 and busy=0 after the edge, and drop_count unchanged by the lost word.
REQ-036 SHALL cover counter wrap: CNT_WIDTH=4 with 17 words pushed -> word_count=1.

Source files
------------

// File: rtl/fifo_write_master.sv
// fifo_write_master
//   Buffers upstream words in a 2-entry in-order skid buffer and writes them
//   into an asynchronous FIFO's write port. A word accepted on one edge is
//   presented on the FIFO write port in the next cycle. The FIFO's full flag
//   stalls writes, and flush discards whatever is still buffered. Statistics
//   counters track words pushed, packets pushed and words discarded.
//
// Ports
//   w_clk        write-domain clock, rising edge
//   resetn       synchronous active-low reset (takes priority over flush)
//   s_valid      upstream word valid
//   s_data       upstream word
//   s_last       upstream word ends a packet
//   s_ready      block can accept a word this cycle
//   flush        discard all buffered, unpushed words
//   fifo_full    async FIFO full flag (write domain)
//   fifo_w_en    FIFO write strobe
//   fifo_w_data  FIFO write data (head of buffer)
//   busy         buffer non-empty or flush in progress
//   word_count   words pushed (wrapping)
//   pkt_count    packets pushed, i.e. pushed words with last set (wrapping)
//   drop_count   words discarded by flush (wrapping)
module fifo_write_master #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  w_clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  flush,
  input  logic                  fifo_full,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_w_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [1:0]           cnt_reg, cnt_next;
  logic                 wr_ptr_reg, rd_ptr_reg;
  logic                 accept, pop;
  logic [DATA_WIDTH:0]  head_entry;
  logic                 head_last;
  logic [CNT_WIDTH-1:0] word_count_reg, pkt_count_reg, drop_count_reg;

  // Handshakes: both are blocked in the FLUSH cycle and in any cycle where
  // flush is asserted, so a flush never races with a push or a pop.
  assign s_ready   = (cnt_reg != 2'd2) && (state_reg != FLUSH) && !flush;
  assign fifo_w_en = (cnt_reg != 2'd0) && !fifo_full && (state_reg != FLUSH) && !flush;
  assign accept    = s_valid && s_ready;
  assign pop       = fifo_w_en;
  assign busy      = (cnt_reg != 2'd0) || (state_reg == FLUSH);

  // Buffer entries {last, data}. Kept as plain registers because the head
  // must be visible combinationally on fifo_w_data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH:0] entry_reg;
      always_ff @(posedge w_clk) begin
        if (accept && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= {s_last, s_data};
        end
      end
    end
  endgenerate

  assign head_entry  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign head_last   = head_entry[DATA_WIDTH];
  assign fifo_w_data = head_entry[DATA_WIDTH-1:0];

  // Next occupancy and state. FLUSH lasts one cycle: nothing can be accepted
  // in it, so cnt_next is 0 and the general rule leads back to IDLE.
  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    if (flush) begin
      cnt_next   = 2'd0;
      state_next = FLUSH;
    end else begin
      cnt_next = cnt_reg + {1'b0, accept} - {1'b0, pop};
      if (cnt_next == 2'd0) begin
        state_next = IDLE;
      end else if (fifo_full) begin
        state_next = STALL;
      end else begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      cnt_reg        <= 2'd0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      word_count_reg <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (flush) begin
        wr_ptr_reg     <= 1'b0;
        rd_ptr_reg     <= 1'b0;
        drop_count_reg <= drop_count_reg + CNT_WIDTH'(cnt_reg);
      end else begin
        wr_ptr_reg <= wr_ptr_reg ^ accept;
        rd_ptr_reg <= rd_ptr_reg ^ pop;
      end
      word_count_reg <= word_count_reg + CNT_WIDTH'(pop);
      pkt_count_reg  <= pkt_count_reg + CNT_WIDTH'(pop && head_last);
    end
  end

  assign word_count = word_count_reg;
  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;

endmodule
